// File: rtl/adc_acq_seq_if.sv
// ADC acquisition sequencer interface: trigger, mask, driver handshake and frame results.
// The slave side is the sequencer; the master side is the trigger source and ADC drivers.
interface adc_acq_seq_if #(
  parameter int NUM_CH = 2,
  parameter int DW     = 16
) ();
  logic                       start_i;
  logic [NUM_CH-1:0]          ch_mask_i;
  logic [NUM_CH-1:0]          adc_ready_i;
  logic [NUM_CH-1:0][DW-1:0]  adc_data_i;
  logic [NUM_CH-1:0]          adc_enable_o;
  logic [NUM_CH-1:0][DW-1:0]  sample_o;
  logic                       eoc_o;
  logic                       busy_o;
  logic [NUM_CH-1:0]          timeout_o;
  logic [NUM_CH-1:0][DW-1:0]  avg_o;
  logic                       avg_valid_o;

  modport slave (
    input  start_i, ch_mask_i, adc_ready_i, adc_data_i,
    output adc_enable_o, sample_o, eoc_o, busy_o, timeout_o, avg_o, avg_valid_o
  );

  modport master (
    output start_i, ch_mask_i, adc_ready_i, adc_data_i,
    input  adc_enable_o, sample_o, eoc_o, busy_o, timeout_o, avg_o, avg_valid_o
  );
endinterface

// File: rtl/adc_acq_seq.sv
// Multi-channel ADC acquisition sequencer: per-frame trigger, capture with timeout,
// code conversion and power-of-two frame averaging. Per-channel datapath lives in adc_acq_lane.
module adc_acq_lane #(
  parameter int DW        = 16,
  parameter int CLAMP_NEG = 1,
  parameter int AVG_LOG2  = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cap,
  input  logic          acc_en,
  input  logic          wrap,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] sample,
  output logic [DW-1:0] avg
);
  localparam int AW = DW + AVG_LOG2;

  logic [AW-1:0] acc, acc_sum;
  logic [DW-1:0] conv;

  // Clamped mode maps signed codes onto an unsigned scale with one bit of headroom.
  always_comb begin
    conv = data;
    if (CLAMP_NEG != 0) conv = data[DW-1] ? '0 : {data[DW-2:0], 1'b0};
  end

  assign acc_sum = acc + AW'(sample);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample <= '0;
      avg    <= '0;
      acc    <= '0;
    end else begin
      if (cap) sample <= conv;
      if (acc_en) begin
        if (wrap) begin
          avg <= acc_sum[AW-1:AVG_LOG2];
          acc <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end
endmodule

module adc_acq_seq #(
  parameter int NUM_CH      = 2,
  parameter int DW          = 16,
  parameter int CLAMP_NEG   = 1,
  parameter int TIMEOUT_CYC = 27000,
  parameter int AVG_LOG2    = 4
) (
  input logic          clk_i,
  input logic          rst_ni,
  adc_acq_seq_if.slave acq
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, COLLECT, FINISH} state_t;

  state_t state, state_nxt;
  logic [NUM_CH-1:0] mask_q, done_q, cap, en_q, to_q;
  logic [TW-1:0]     timer;
  logic [CW-1:0]     frame_cnt;
  logic              start_ok, expire, all_done, finish, wrap;
  logic              eoc_q, busy_q, avgv_q;
  logic [NUM_CH-1:0][DW-1:0] sample_q, avg_q;

  assign start_ok = acq.start_i && (acq.ch_mask_i != '0);
  assign expire   = ((state == WAIT_BUSY) || (state == COLLECT)) && (timer == TW'(1));
  assign all_done = (done_q & mask_q) == mask_q;
  assign cap      = (state == COLLECT) ? (mask_q & acq.adc_ready_i & ~done_q) : '0;
  assign finish   = (state == FINISH);
  assign wrap     = (frame_cnt == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Waiting for every masked driver to go busy keeps a leftover ready from being captured.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_ok) state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (expire) state_nxt = FINISH;
                 else if ((acq.adc_ready_i & mask_q) == '0) state_nxt = COLLECT;
      COLLECT:   if (expire || all_done) state_nxt = FINISH;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q    <= '0;
      done_q    <= '0;
      en_q      <= '0;
      to_q      <= '0;
      timer     <= '0;
      frame_cnt <= '0;
      eoc_q     <= 1'b0;
      busy_q    <= 1'b0;
      avgv_q    <= 1'b0;
    end else begin
      eoc_q  <= finish;
      avgv_q <= finish && wrap;
      busy_q <= (state_nxt != IDLE);
      if (finish) frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
      case (state)
        IDLE: if (start_ok) begin
          mask_q <= acq.ch_mask_i;
          en_q   <= acq.ch_mask_i;
          done_q <= '0;
          to_q   <= '0;
          timer  <= TW'(TIMEOUT_CYC);
        end
        WAIT_BUSY, COLLECT: begin
          timer  <= timer - 1'b1;
          done_q <= done_q | cap;
          en_q   <= en_q & ~cap;
          // A capture landing on the expiry cycle still counts for that channel.
          if (expire) begin
            to_q <= mask_q & ~done_q & ~cap;
            en_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    adc_acq_lane #(.DW(DW), .CLAMP_NEG(CLAMP_NEG), .AVG_LOG2(AVG_LOG2)) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .cap    (cap[g]),
      .acc_en (finish),
      .wrap   (wrap),
      .data   (acq.adc_data_i[g]),
      .sample (sample_q[g]),
      .avg    (avg_q[g])
    );
  end

  assign acq.adc_enable_o = en_q;
  assign acq.sample_o     = sample_q;
  assign acq.eoc_o        = eoc_q;
  assign acq.busy_o       = busy_q;
  assign acq.timeout_o    = to_q;
  assign acq.avg_o        = avg_q;
  assign acq.avg_valid_o  = avgv_q;
endmodule

// File: tb/tb_adc_acq_seq.sv
// Directed bench for adc_acq_seq: a clamped two-channel unit with a short timeout
// and a raw single-channel unit with a four-frame averaging window.
module tb_adc_acq_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  adc_acq_seq_if #(.NUM_CH(2), .DW(16)) ifa ();
  adc_acq_seq_if #(.NUM_CH(1), .DW(16)) ifb ();

  adc_acq_seq #(.NUM_CH(2), .DW(16), .CLAMP_NEG(1), .TIMEOUT_CYC(100), .AVG_LOG2(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .acq(ifa));
  adc_acq_seq #(.NUM_CH(1), .DW(16), .CLAMP_NEG(0), .TIMEOUT_CYC(27000), .AVG_LOG2(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .acq(ifb));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One frame on unit A: drivers go busy 2 cycles after start, return ready 3 cycles later.
  task automatic a_frame(input logic [1:0] m, input logic [15:0] d0, input logic [15:0] d1,
                         output int n_eoc, output logic [1:0] en_seen, output logic busy_seen);
    ifa.ch_mask_i = m;
    ifa.start_i   = 1'b1;
    tick(1);
    ifa.start_i = 1'b0;
    en_seen   = ifa.adc_enable_o;
    busy_seen = ifa.busy_o;
    n_eoc     = 0;
    tick(2);
    ifa.adc_ready_i = 2'b00;
    tick(3);
    ifa.adc_data_i[0] = d0;
    ifa.adc_data_i[1] = d1;
    ifa.adc_ready_i   = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      en_seen   |= ifa.adc_enable_o;
      busy_seen |= ifa.busy_o;
      if (ifa.eoc_o) n_eoc++;
    end
  endtask

  task automatic b_frame(input logic [15:0] d, output int n_eoc, output logic av);
    ifb.ch_mask_i = 1'b1;
    ifb.start_i   = 1'b1;
    tick(1);
    ifb.start_i = 1'b0;
    n_eoc = 0;
    av    = 1'b0;
    tick(2);
    ifb.adc_ready_i = 1'b0;
    tick(3);
    ifb.adc_data_i[0] = d;
    ifb.adc_ready_i   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (ifb.eoc_o) n_eoc++;
      av |= ifb.avg_valid_o;
    end
  endtask

  initial begin
    int         n;
    logic [1:0] en_seen;
    logic       busy_seen, av;

    rst_n = 1'b0;
    ifa.start_i = 1'b0; ifa.ch_mask_i = 2'b00; ifa.adc_ready_i = 2'b11; ifa.adc_data_i = '0;
    ifb.start_i = 1'b0; ifb.ch_mask_i = 1'b0;  ifb.adc_ready_i = 1'b1;  ifb.adc_data_i = '0;
    tick(2);
    chk("rst_en",   ifa.adc_enable_o, 2'b00);
    chk("rst_smp",  ifa.sample_o, 32'h0);
    chk("rst_eoc",  ifa.eoc_o, 1'b0);
    chk("rst_busy", ifa.busy_o, 1'b0);
    chk("rst_to",   ifa.timeout_o, 2'b00);
    chk("rst_avg",  ifa.avg_o, 32'h0);
    chk("rst_avgv", ifa.avg_valid_o, 1'b0);
    chk("rst_b",    {ifb.sample_o, ifb.avg_o, ifb.eoc_o, ifb.busy_o}, 34'h0);
    rst_n = 1'b1;
    tick(1);

    // Both channels, ch0 at 50 cycles, ch1 (negative code) at 80 cycles.
    ifa.ch_mask_i = 2'b11;
    ifa.start_i   = 1'b1;
    tick(1);
    ifa.start_i = 1'b0;
    chk("t1_en", ifa.adc_enable_o, 2'b11);
    chk("t1_busy", ifa.busy_o, 1'b1);
    tick(2);
    ifa.adc_ready_i = 2'b00;
    tick(47);
    ifa.adc_data_i[0] = 16'h1234;
    ifa.adc_ready_i[0] = 1'b1;
    tick(1);
    chk("t1_smp0", ifa.sample_o[0], 16'h2468);
    chk("t1_en0",  ifa.adc_enable_o, 2'b10);
    ifa.adc_data_i[0] = 16'h5555;
    tick(29);
    ifa.adc_data_i[1] = 16'h8001;
    ifa.adc_ready_i[1] = 1'b1;
    tick(1);
    chk("t1_smp1", ifa.sample_o[1], 16'h0000);
    chk("t1_hold0", ifa.sample_o[0], 16'h2468);
    chk("t1_en1",  ifa.adc_enable_o, 2'b00);
    chk("t1_eoc_early", ifa.eoc_o, 1'b0);
    tick(1);
    chk("t1_eoc_fin", ifa.eoc_o, 1'b0);
    chk("t1_busy_fin", ifa.busy_o, 1'b1);
    tick(1);
    chk("t1_eoc", ifa.eoc_o, 1'b1);
    chk("t1_idle", ifa.busy_o, 1'b0);
    chk("t1_to", ifa.timeout_o, 2'b00);
    chk("t1_avgv", ifa.avg_valid_o, 1'b1);
    chk("t1_avg", ifa.avg_o, 32'h0000_2468);
    tick(1);
    chk("t1_eoc_end", ifa.eoc_o, 1'b0);

    a_frame(2'b11, 16'h0011, 16'h0123, n, en_seen, busy_seen);
    chk("f2_eoc", n, 1);
    chk("f2_smp", ifa.sample_o, 32'h0246_0022);

    // ch1 never returns ready: timeout at cycle 100.
    ifa.ch_mask_i = 2'b11;
    ifa.start_i   = 1'b1;
    tick(1);
    ifa.start_i = 1'b0;
    tick(2);
    ifa.adc_ready_i = 2'b00;
    tick(3);
    ifa.adc_data_i[0] = 16'h0100;
    ifa.adc_data_i[1] = 16'h7777;
    ifa.adc_ready_i   = 2'b01;
    tick(94);
    chk("t3_en_pre", ifa.adc_enable_o, 2'b10);
    chk("t3_to_pre", ifa.timeout_o, 2'b00);
    chk("t3_smp0", ifa.sample_o[0], 16'h0200);
    tick(1);
    chk("t3_en", ifa.adc_enable_o, 2'b00);
    chk("t3_to", ifa.timeout_o, 2'b10);
    chk("t3_busy", ifa.busy_o, 1'b1);
    tick(1);
    chk("t3_eoc", ifa.eoc_o, 1'b1);
    chk("t3_smp1", ifa.sample_o[1], 16'h0246);
    chk("t3_avg", ifa.avg_o, 32'h0246_0200);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (ifa.eoc_o) n++;
    end
    chk("t3_one_eoc", n, 0);
    chk("t3_to_hold", ifa.timeout_o, 2'b10);
    ifa.adc_ready_i = 2'b11;

    // ch1 masked out, although its driver shows ready with fresh data.
    a_frame(2'b01, 16'h0007, 16'h0999, n, en_seen, busy_seen);
    chk("t5_eoc", n, 1);
    chk("t5_en_seen", en_seen, 2'b01);
    chk("t5_smp", ifa.sample_o, 32'h0246_000E);
    chk("t5_to", ifa.timeout_o, 2'b00);
    a_frame(2'b00, 16'h0001, 16'h0001, n, en_seen, busy_seen);
    chk("t5_m0_eoc", n, 0);
    chk("t5_m0_busy", busy_seen, 1'b0);
    chk("t5_m0_en", en_seen, 2'b00);

    // Raw conversion on unit B; a start during COLLECT is not queued.
    ifb.ch_mask_i = 1'b1;
    ifb.start_i   = 1'b1;
    tick(1);
    ifb.start_i = 1'b0;
    chk("t2_busy", ifb.busy_o, 1'b1);
    tick(2);
    ifb.adc_ready_i = 1'b0;
    tick(2);
    ifb.start_i = 1'b1;
    tick(1);
    ifb.start_i = 1'b0;
    ifb.adc_data_i[0] = 16'hFFF0;
    ifb.adc_ready_i   = 1'b1;
    tick(1);
    chk("t2_smp", ifb.sample_o, 16'hFFF0);
    n = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ifb.eoc_o) n++;
      if (i >= 5) busy_seen |= ifb.busy_o;
    end
    chk("t2_eoc", n, 1);
    chk("t2_no_second", busy_seen, 1'b0);

    // Reset asserted mid-COLLECT, off the clock edge.
    ifa.ch_mask_i = 2'b11;
    ifa.start_i   = 1'b1;
    tick(1);
    ifa.start_i = 1'b0;
    tick(2);
    ifa.adc_ready_i = 2'b00;
    tick(3);
    chk("t6_en_pre", ifa.adc_enable_o, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_en", ifa.adc_enable_o, 2'b00);
    chk("t6_busy", ifa.busy_o, 1'b0);
    chk("t6_smp", ifa.sample_o, 32'h0);
    chk("t6_avg", ifa.avg_o, 32'h0);
    chk("t6_b", {ifb.sample_o, ifb.avg_o}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    ifa.adc_ready_i = 2'b11;
    tick(2);
    chk("t6_idle", ifa.busy_o, 1'b0);
    a_frame(2'b11, 16'h0005, 16'h0006, n, en_seen, busy_seen);
    chk("t6_eoc", n, 1);
    chk("t6_smp", ifa.sample_o, 32'h000C_000A);

    // Four-frame window on unit B: (100+200+300+401)/4 = 250.
    b_frame(16'd100, n, av); chk("avg_f1", {n[3:0], av}, {4'd1, 1'b0});
    b_frame(16'd200, n, av); chk("avg_f2", {n[3:0], av}, {4'd1, 1'b0});
    b_frame(16'd300, n, av); chk("avg_f3", {n[3:0], av}, {4'd1, 1'b0});
    b_frame(16'd401, n, av); chk("avg_f4", {n[3:0], av}, {4'd1, 1'b1});
    chk("avg_val", ifb.avg_o, 16'd250);
    chk("avg_smp", ifb.sample_o, 16'd401);
    b_frame(16'd1000, n, av); chk("avg_f5", {n[3:0], av}, {4'd1, 1'b0});
    b_frame(16'd2000, n, av); chk("avg_f6", {n[3:0], av}, {4'd1, 1'b0});
    b_frame(16'd3000, n, av); chk("avg_f7", {n[3:0], av}, {4'd1, 1'b0});
    chk("avg_hold", ifb.avg_o, 16'd250);
    b_frame(16'd4000, n, av); chk("avg_f8", {n[3:0], av}, {4'd1, 1'b1});
    chk("avg_val2", ifb.avg_o, 16'd2500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
